operand_stack: RTL
==================

# operand_stack

Hardware operand stack for the 16-bit stack processor. It is the storage end of the control/data-memory path: it accepts the `stackWriteData` word produced by getin, lui, pushi and push instructions, and it supplies the top-of-stack word that pop writes to data memory as `memWriteData`. It holds a fixed number of entries, supports push, pop and replace-top in one cycle, and reports full/empty status plus sticky overflow and underflow errors.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of a stack word.
- `DEPTH`, 16, number of entries. Must be a power of two, at least 2.
- `PTR_WIDTH`, log2(`DEPTH`), width of the entry index.

Ports:
- `CLK`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push`  in  1  request to write `pushData` as the new top.
- `pop`  in  1  request to remove the top entry.
- `pushData`  in  DATA_WIDTH  word to push. Driven from `stackWriteData`.
- `clearErr`  in  1  synchronous clear of the sticky error flags.
- `top`  out  DATA_WIDTH  current top entry. Feeds `memWriteData`.
- `next`  out  DATA_WIDTH  entry below the top.
- `count`  out  PTR_WIDTH+1  number of valid entries, 0..DEPTH.
- `empty`  out  1  high when `count` == 0.
- `full`  out  1  high when `count` == DEPTH.
- `overflow`  out  1  sticky: a push was dropped.
- `underflow`  out  1  sticky: a pop was dropped.

## Operation
- State consists of `count`, the entry array, and the two sticky flags.
- The top entry is at index `count`-1. Array contents are never cleared.
- `top` reads 0 when `count` == 0. `next` reads 0 when `count` < 2.
- Per-edge behaviour, with {push,pop} sampled at the rising edge:
  - 00: hold.
  - 10, not full: write `pushData` at index `count`; `count`+1.
  - 10, full: drop the push; `count` and contents unchanged; set `overflow`.
  - 01, not empty: `count`−1. The old entry stays in the array but is not visible.
  - 01, empty: drop the pop; set `underflow`.
  - 11, not empty: replace-top. Write `pushData` at index `count`−1; `count` unchanged. This works when full and does not set `overflow`.
  - 11, empty: behaves as a plain push (`count` becomes 1); set `underflow`.
- Sticky flags:
  - `clearErr` clears both flags on the edge.
  - If a new error occurs on the same edge as `clearErr`, the new error wins and its flag ends up set.
- Width rules:
  - `count` never wraps. The full and empty guards prevent it.
  - All index arithmetic is PTR_WIDTH bits.

## Timing
- Reset (asynchronous assertion, held until deassertion):
  - `count`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, `top`=0, `next`=0.
  - The array is not reset; outputs are masked by `count`.
- Latency is one cycle. `top`, `next`, `count`, `empty` and `full` reflect an operation immediately after the edge that accepts it. They are combinational from registered state, with no extra register stage.
- There is no handshake or backpressure. Requests are single-cycle strobes and every strobe is consumed on its edge, either accepted or dropped with a flag.
- Reset mid-sequence (for example between push and the next pop) discards all state immediately. Requests sampled while `reset` is high are ignored.
- A pop followed by a push on the next edge must reuse the freed index, so the new word becomes `top`.

## Structure
- Shared package / include `stack_defs` holds:
  - `DATA_WIDTH`, `DEPTH` and derived `PTR_WIDTH`.
  - Opcode constants for push-type instructions (getin 0x0004, pushi 0x7, push 0x6, lui 0x8) and pop 0x5, so the control unit and this block agree.
- Natural sub-module: `stack_regfile`, with one synchronous write port (index, data, enable) and two asynchronous read ports (top index, next index).
- `operand_stack` contains only the pointer/count logic, the guards and the flags.

## Test plan
- After reset: push 0x0013 → `top`=0x0013, `count`=1, `empty`=0. Then push 0x0003, push 0x3000 → `top`=0x3000, `next`=0x0003, `count`=3.
- From that state, pop → `top`=0x0003, `next`=0x0013, `count`=2. Then push 0x0005 → `top`=0x0005, `count`=3.
- From that state, push=pop=1 with `pushData`=0x3333 → `top`=0x3333, `next`=0x0003, `count`=3, both flags 0.
- Fill with 0x1000+i for i=0..15 → `full`=1. Then push 0xFFFF → `top`=0x100F, `count`=16, `overflow`=1. Then push+pop with 0xAAAA → `top`=0xAAAA, `count`=16.
- From empty, pop → `count`=0, `top`=0, `underflow`=1. Then `clearErr` → `underflow`=0. Then push+pop with 0x0042 → `count`=1, `top`=0x0042, `underflow`=1.
- With `count`=3, assert `reset` between edges → all outputs read their reset values at once. Then push 0x0007 → `top`=0x0007, `next`=0, `count`=1.

Source files
------------

// File: rtl/operand_stack_pkg.sv
// Shared stack sizing and the opcodes that touch the operand stack.
// Imported by the stack, its register file and its interface.
package stack_defs;

  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 16;
  localparam int PTR_WIDTH  = $clog2(DEPTH);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [PTR_WIDTH-1:0]  ptr_t;
  typedef logic [PTR_WIDTH:0]    cnt_t;

  // getin is a full instruction word; the rest are 4-bit opcodes
  localparam logic [15:0] INSTR_GETIN = 16'h0004;
  localparam logic [3:0]  OP_POP      = 4'h5;
  localparam logic [3:0]  OP_PUSH     = 4'h6;
  localparam logic [3:0]  OP_PUSHI    = 4'h7;
  localparam logic [3:0]  OP_LUI      = 4'h8;

endpackage

// File: rtl/operand_stack_if.sv
// Request strobes and status of the operand stack.
// master drives requests, slave is the stack.
interface operand_stack_if;
  import stack_defs::*;

  logic  push;
  logic  pop;
  word_t pushData;
  logic  clearErr;
  word_t top;
  word_t next;
  cnt_t  count;
  logic  empty;
  logic  full;
  logic  overflow;
  logic  underflow;

  modport master (
    output push, pop, pushData, clearErr,
    input  top, next, count, empty, full,
    input  overflow, underflow
  );

  modport slave (
    input  push, pop, pushData, clearErr,
    output top, next, count, empty, full,
    output overflow, underflow
  );

endinterface

// File: rtl/operand_stack_regfile.sv
// Stack entry array: one synchronous write port, two async reads.
// Contents are deliberately not reset; the stack masks by count.
module stack_regfile
  import stack_defs::*;
(
  input  logic  CLK,
  input  logic  wrEn,
  input  ptr_t  wrIdx,
  input  word_t wrData,
  input  ptr_t  topIdx,
  input  ptr_t  nextIdx,
  output word_t topData,
  output word_t nextData
);

  word_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wrEn) begin
      mem[wrIdx] <= wrData;
    end
  end

  assign topData  = mem[topIdx];
  assign nextData = mem[nextIdx];

endmodule

// File: rtl/operand_stack.sv
// Operand stack: count/pointer logic, full/empty guards and
// sticky error flags around the stack_regfile entry array.
module operand_stack
  import stack_defs::*;
(
  input  logic            CLK,
  input  logic            reset,
  operand_stack_if.slave  bus
);

  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_TWO  = cnt_t'(2);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t PTR_TWO  = ptr_t'(2);

  cnt_t  countQ, countD;
  logic  ovfQ, ovfD;
  logic  unfQ, unfD;
  logic  ovfSet, unfSet;
  logic  wrEn;
  ptr_t  wrIdx;
  ptr_t  freeIdx, topIdx, nextIdx;
  word_t topData, nextData;
  logic  isEmpty, isFull;

  assign isEmpty = (countQ == '0);
  assign isFull  = (countQ == CNT_FULL);

  // Low bits of count wrap to 0 when full, so top is DEPTH-1
  assign freeIdx = countQ[PTR_WIDTH-1:0];
  assign topIdx  = freeIdx - PTR_ONE;
  assign nextIdx = freeIdx - PTR_TWO;

  always_comb begin
    countD = countQ;
    wrEn   = 1'b0;
    wrIdx  = freeIdx;
    ovfSet = 1'b0;
    unfSet = 1'b0;
    unique case (1'b1)
      (bus.push && !bus.pop): begin
        if (isFull) begin
          ovfSet = 1'b1;
        end else begin
          wrEn   = 1'b1;
          countD = countQ + CNT_ONE;
        end
      end
      (!bus.push && bus.pop): begin
        if (isEmpty) begin
          unfSet = 1'b1;
        end else begin
          countD = countQ - CNT_ONE;
        end
      end
      (bus.push && bus.pop): begin
        wrEn = 1'b1;
        if (isEmpty) begin
          countD = CNT_ONE;
          unfSet = 1'b1;
        end else begin
          wrIdx = topIdx;
        end
      end
      default: begin
        countD = countQ;
      end
    endcase
  end

  // A fresh error on the clearing edge keeps its flag set
  assign ovfD = ovfSet | (ovfQ & ~bus.clearErr);
  assign unfD = unfSet | (unfQ & ~bus.clearErr);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      countQ <= '0;
      ovfQ   <= 1'b0;
      unfQ   <= 1'b0;
    end else begin
      countQ <= countD;
      ovfQ   <= ovfD;
      unfQ   <= unfD;
    end
  end

  stack_regfile u_regfile (
    .CLK      (CLK),
    .wrEn     (wrEn && !reset),
    .wrIdx    (wrIdx),
    .wrData   (bus.pushData),
    .topIdx   (topIdx),
    .nextIdx  (nextIdx),
    .topData  (topData),
    .nextData (nextData)
  );

  assign bus.top       = isEmpty ? '0 : topData;
  assign bus.next      = (countQ < CNT_TWO) ? '0 : nextData;
  assign bus.count     = countQ;
  assign bus.empty     = isEmpty;
  assign bus.full      = isFull;
  assign bus.overflow  = ovfQ;
  assign bus.underflow = unfQ;

endmodule
